mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 13 +
 rtl/mem_stage_ctrl_sram_wait_timer.sv | 35 +++
 rtl/mem_stage_ctrl.sv | 119 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions: register-index width, default datapath width
// and the MEM-stage controller state encoding.
package mem_stage_ctrl_pkg;

  localparam int REG_IDX_W   = 4;
  localparam int PIPE_DATA_W = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_sram_wait_timer.sv
// Counts SRAM wait cycles of the current access and raises a sticky timeout
// flag once the count reaches TIMEOUT.
module sram_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic waiting,
  output logic err_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] wait_cnt;
  logic [7:0] cnt_inc;

  // Saturate so a stuck access never wraps the count back below TIMEOUT.
  assign cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      if (start)
        wait_cnt <= 8'd0;
      else if (waiting)
        wait_cnt <= cnt_inc;
      if (waiting && (cnt_inc == TIMEOUT_CNT))
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: SRAM handshake, pipeline freeze, MEM/WB
// registers and forwarding outputs.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = PIPE_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exe_valid,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic                 exe_mem_w_en,
  input  logic [DATA_W-1:0]    exe_alu_res,
  input  logic [DATA_W-1:0]    exe_st_val,
  output logic                 sram_req,
  output logic                 sram_we,
  output logic [DATA_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  input  logic                 sram_ready,
  output logic                 freeze,
  output logic [REG_IDX_W-1:0] MEM_dest,
  output logic                 MEM_wb_en,
  output logic [DATA_W-1:0]    MEM_val,
  output logic [REG_IDX_W-1:0] WB_dest,
  output logic                 WB_wb_en,
  output logic [DATA_W-1:0]    WB_value,
  output logic                 err_timeout
);

  mem_state_t state, state_nxt;

  logic                 vld_p1, wb_en_p1, r_en_p1, w_en_p1;
  logic [REG_IDX_W-1:0] dest_p1;
  logic [DATA_W-1:0]    alu_res_p1, st_val_p1;
  logic                 exe_is_mem;

  assign exe_is_mem = exe_valid & (exe_mem_r_en | exe_mem_w_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sram_req  = 1'b0;
    sram_we   = 1'b0;
    freeze    = 1'b0;
    case (state)
      ST_IDLE: state_nxt = exe_is_mem ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: begin
        sram_req = 1'b1;
        sram_we  = w_en_p1;
        freeze   = ~sram_ready;
        if (sram_ready) state_nxt = exe_is_mem ? ST_ACCESS : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // MEM register stays put for the whole access, which keeps the SRAM address/data stable.
  assign sram_addr  = alu_res_p1;
  assign sram_wdata = st_val_p1;

  // EXE -> MEM stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      wb_en_p1   <= 1'b0;
      r_en_p1    <= 1'b0;
      w_en_p1    <= 1'b0;
      dest_p1    <= '0;
      alu_res_p1 <= '0;
      st_val_p1  <= '0;
    end else if (!freeze) begin
      vld_p1     <= exe_valid;
      wb_en_p1   <= exe_valid & exe_wb_en;
      r_en_p1    <= exe_valid & exe_mem_r_en;
      w_en_p1    <= exe_valid & exe_mem_w_en;
      dest_p1    <= exe_dest;
      alu_res_p1 <= exe_alu_res;
      st_val_p1  <= exe_st_val;
    end
  end

  assign MEM_dest  = dest_p1;
  assign MEM_val   = alu_res_p1;
  assign MEM_wb_en = vld_p1 & wb_en_p1 & ~r_en_p1;

  // MEM -> WB stage; a frozen cycle writes a bubble so no register write repeats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_dest  <= '0;
      WB_wb_en <= 1'b0;
      WB_value <= '0;
    end else if (freeze) begin
      WB_wb_en <= 1'b0;
    end else begin
      WB_dest  <= dest_p1;
      WB_wb_en <= vld_p1 & wb_en_p1;
      WB_value <= r_en_p1 ? sram_rdata : alu_res_p1;
    end
  end

  sram_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (~freeze & exe_is_mem),
    .waiting     ((state == ST_ACCESS) & ~sram_ready),
    .err_timeout (err_timeout)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed programs, a random program and a stuck
// SRAM, checked against per-instruction expectations.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en;
  logic [3:0]  exe_dest;
  logic [31:0] exe_alu_res, exe_st_val;
  logic        sram_req, sram_we, sram_ready;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        freeze, MEM_wb_en, WB_wb_en, err_timeout;
  logic [3:0]  MEM_dest, WB_dest;
  logic [31:0] MEM_val, WB_value;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          valid;
    logic [3:0]  dest;
    bit          wb_en, r_en, w_en;
    logic [31:0] alu, st, rdata;
    int          lat;
  } instr_t;

  instr_t prog [0:63];

  mem_stage_ctrl #(.TIMEOUT(255), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_alu_res(exe_alu_res), .exe_st_val(exe_st_val),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .freeze(freeze), .MEM_dest(MEM_dest), .MEM_wb_en(MEM_wb_en), .MEM_val(MEM_val),
    .WB_dest(WB_dest), .WB_wb_en(WB_wb_en), .WB_value(WB_value),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(bit v, logic [3:0] d, bit wb, bit r, bit w,
                                logic [31:0] alu, logic [31:0] st, logic [31:0] rd, int lat);
    instr_t t;
    t.valid = v; t.dest = d; t.wb_en = wb; t.r_en = r; t.w_en = w;
    t.alu = alu; t.st = st; t.rdata = rd; t.lat = lat;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    exe_valid    = t.valid;
    exe_dest     = t.dest;
    exe_wb_en    = t.wb_en;
    exe_mem_r_en = t.r_en;
    exe_mem_w_en = t.w_en;
    exe_alu_res  = t.alu;
    exe_st_val   = t.st;
  endtask

  // Runs prog[0..n-1] followed by one bubble; expectations come from each
  // instruction's kind and its programmed SRAM latency.
  task automatic run_prog(input int n);
    instr_t cur, prev;
    bit mem, prev_wb;
    int lat;
    prog[n] = mk(0, 4'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
    prev    = prog[n];
    drive(prog[0]);
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) begin
      cur = prog[i];
      mem = cur.valid && (cur.r_en || cur.w_en);
      lat = mem ? cur.lat : 0;
      drive(prog[(i < n) ? i + 1 : n]);
      for (int c = 0; c <= lat; c++) begin
        if (mem) begin
          sram_ready = (c == lat);
          sram_rdata = (c == lat) ? cur.rdata : $urandom;
        end else begin
          sram_ready = 1'($urandom);
          sram_rdata = $urandom;
        end
        #1;
        chk("freeze", freeze, mem && (c < lat));
        chk("sram_req", sram_req, mem);
        chk("sram_we", sram_we, mem && cur.w_en);
        if (mem) chk("sram_addr", sram_addr, cur.alu);
        if (mem && cur.w_en) chk("sram_wdata", sram_wdata, cur.st);
        chk("MEM_wb_en", MEM_wb_en, cur.valid && cur.wb_en && !cur.r_en);
        if (cur.valid) begin
          chk("MEM_dest", MEM_dest, cur.dest);
          chk("MEM_val", MEM_val, cur.alu);
        end
        prev_wb = (c == 0) && prev.valid && prev.wb_en;
        chk("WB_wb_en", WB_wb_en, prev_wb);
        if (prev_wb) begin
          chk("WB_dest", WB_dest, prev.dest);
          chk("WB_value", WB_value, prev.r_en ? prev.rdata : prev.alu);
        end
        chk("err_timeout", err_timeout, 1'b0);
        @(posedge clk); #1;
      end
      prev = cur;
    end
    sram_ready = 1'b0;
  endtask

  initial begin
    instr_t t;
    int kind;
    rst_n = 1'b0;
    sram_ready = 1'b0;
    sram_rdata = 32'd0;
    drive(mk(0, 4'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0));
    #2;
    chk("rst_sram_req", sram_req, 1'b0);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_MEM_wb_en", MEM_wb_en, 1'b0);
    chk("rst_WB_wb_en", WB_wb_en, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU op, then a 3-cycle load, then a single-cycle store
    prog[0] = mk(1, 4'd3, 1, 0, 0, 32'h10, 32'h0, 32'h0, 0);
    prog[1] = mk(1, 4'd5, 1, 1, 0, 32'h100, 32'h0, 32'hCAFE, 3);
    prog[2] = mk(1, 4'd7, 0, 0, 1, 32'h40, 32'h55, 32'h0, 0);
    run_prog(3);

    // Back-to-back loads acknowledged immediately, plus a load with wb_en=0
    prog[0] = mk(1, 4'd1, 1, 1, 0, 32'h200, 32'h0, 32'h1111, 0);
    prog[1] = mk(1, 4'd2, 1, 1, 0, 32'h204, 32'h0, 32'h2222, 0);
    prog[2] = mk(1, 4'd4, 0, 1, 0, 32'h208, 32'h0, 32'h3333, 1);
    run_prog(3);

    // Random program
    for (int i = 0; i < 48; i++) begin
      kind = int'($urandom_range(0, 3));
      t = mk(kind != 0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
      if (kind == 1) begin t.r_en = 0; t.w_en = 0; end
      if (kind == 2) begin t.r_en = 1; t.w_en = 0; end
      if (kind == 3) begin t.r_en = 0; t.w_en = 1; t.wb_en = 0; end
      prog[i] = t;
    end
    run_prog(48);

    // SRAM never answers: timeout after 255 wait cycles, then reset mid-access
    drive(mk(1, 4'd9, 1, 1, 0, 32'h300, 32'h0, 32'h0, 0));
    sram_ready = 1'b0;
    @(posedge clk); #1;
    drive(mk(0, 4'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0));
    for (int k = 0; k < 300; k++) begin
      chk("to_err", err_timeout, k >= 255);
      chk("to_freeze", freeze, 1'b1);
      chk("to_addr", sram_addr, 32'h300);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_sram_req", sram_req, 1'b0);
    chk("arst_sram_we", sram_we, 1'b0);
    chk("arst_freeze", freeze, 1'b0);
    chk("arst_MEM_wb_en", MEM_wb_en, 1'b0);
    chk("arst_WB_wb_en", WB_wb_en, 1'b0);
    chk("arst_err", err_timeout, 1'b0);
    chk("arst_sram_addr", sram_addr, 32'd0);
    chk("arst_MEM_val", MEM_val, 32'd0);
    chk("arst_WB_value", WB_value, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_WB_wb_en", WB_wb_en, 1'b0);
    chk("post_rst_sram_req", sram_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
